// File: rtl/sdram_port_arbiter.sv
// Burst-level arbiter sharing the SDRAM controller client port between video and CPU.
// Optional starvation guard for the CPU is enabled with `define SDRAM_ARB_FAIR_EN.
module sdram_port_arbiter #(
  parameter int MAX_VID_RUN = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        vid_rd_i,
  input  logic [23:0] vid_addr_x16_i,
  input  logic        vid_ack_i,
  output logic        vid_rdy_o,
  output logic [15:0] vid_rdata_o,
  input  logic        cpu_rd_i,
  input  logic        cpu_wr_i,
  input  logic [23:0] cpu_addr_x16_i,
  input  logic [15:0] cpu_wdata_i,
  input  logic        cpu_ack_i,
  output logic        cpu_rdy_o,
  output logic [15:0] cpu_rdata_o,
  output logic        sdram_rd_o,
  output logic        sdram_wr_o,
  output logic [23:0] sdram_addr_x16_o,
  output logic [15:0] sdram_wdata_o,
  output logic        sdram_ack_o,
  input  logic        sdram_rdy_i,
  input  logic [15:0] sdram_rdata_i
);

  typedef enum logic [1:0] {IDLE, VID, CPU, RELEASE} state_t;

  state_t state_q, state_d;
  logic   cpu_req;
  logic   cpu_turn;

  assign cpu_req = cpu_rd_i | cpu_wr_i;

`ifdef SDRAM_ARB_FAIR_EN
  localparam int RUN_W = $clog2(MAX_VID_RUN + 1);

  logic [RUN_W-1:0] vid_run_q, vid_run_d;

  assign cpu_turn = (vid_run_q == RUN_W'(MAX_VID_RUN));

  // Count back-to-back video grants only while the CPU is actually waiting.
  always_comb begin
    vid_run_d = vid_run_q;
    if (state_q == IDLE) begin
      if (!cpu_req || state_d == CPU) begin
        vid_run_d = '0;
      end else if (state_d == VID && !cpu_turn) begin
        vid_run_d = vid_run_q + RUN_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vid_run_q <= '0;
    end else begin
      vid_run_q <= vid_run_d;
    end
  end
`else
  // Never true: strict video priority.
  assign cpu_turn = (MAX_VID_RUN < 0);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (vid_rd_i && !(cpu_req && cpu_turn)) begin
          state_d = VID;
        end else if (cpu_req) begin
          state_d = CPU;
        end
      end
      VID:     if (vid_ack_i) state_d = RELEASE;
      CPU:     if (cpu_ack_i) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ownership is held until the owner's ACK even if its request drops early.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    sdram_rd_o       = 1'b0;
    sdram_wr_o       = 1'b0;
    sdram_addr_x16_o = '0;
    sdram_wdata_o    = '0;
    sdram_ack_o      = 1'b0;
    vid_rdy_o        = 1'b0;
    cpu_rdy_o        = 1'b0;
    case (state_q)
      VID: begin
        sdram_rd_o       = vid_rd_i;
        sdram_addr_x16_o = vid_addr_x16_i;
        sdram_ack_o      = vid_ack_i;
        vid_rdy_o        = sdram_rdy_i;
      end
      CPU: begin
        sdram_rd_o       = cpu_rd_i;
        sdram_wr_o       = cpu_wr_i;
        sdram_addr_x16_o = cpu_addr_x16_i;
        sdram_wdata_o    = cpu_wdata_i;
        sdram_ack_o      = cpu_ack_i;
        cpu_rdy_o        = sdram_rdy_i;
      end
      default: ;
    endcase
  end

  assign vid_rdata_o = sdram_rdata_i;
  assign cpu_rdata_o = sdram_rdata_i;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: the bench plays the SDRAM controller,
// queues the expected words per burst and a negedge monitor checks each delivered word.
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        vid_rd_i, vid_ack_i, vid_rdy_o;
  logic [23:0] vid_addr_x16_i;
  logic [15:0] vid_rdata_o;
  logic        cpu_rd_i, cpu_wr_i, cpu_ack_i, cpu_rdy_o;
  logic [23:0] cpu_addr_x16_i;
  logic [15:0] cpu_wdata_i, cpu_rdata_o;
  logic        sdram_rd_o, sdram_wr_o, sdram_ack_o, sdram_rdy_i;
  logic [23:0] sdram_addr_x16_o;
  logic [15:0] sdram_wdata_o, sdram_rdata_i;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.MAX_VID_RUN(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .vid_rd_i(vid_rd_i), .vid_addr_x16_i(vid_addr_x16_i), .vid_ack_i(vid_ack_i),
    .vid_rdy_o(vid_rdy_o), .vid_rdata_o(vid_rdata_o),
    .cpu_rd_i(cpu_rd_i), .cpu_wr_i(cpu_wr_i), .cpu_addr_x16_i(cpu_addr_x16_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_ack_i(cpu_ack_i),
    .cpu_rdy_o(cpu_rdy_o), .cpu_rdata_o(cpu_rdata_o),
    .sdram_rd_o(sdram_rd_o), .sdram_wr_o(sdram_wr_o), .sdram_addr_x16_o(sdram_addr_x16_o),
    .sdram_wdata_o(sdram_wdata_o), .sdram_ack_o(sdram_ack_o),
    .sdram_rdy_i(sdram_rdy_i), .sdram_rdata_i(sdram_rdata_i)
  );

  typedef struct {
    bit          cpu;
    logic [23:0] addr;
    logic        wr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0, n_mis = 0;
  int   vid_words = 0, cpu_words = 0, ack_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every word handed to a client must match the head of the scoreboard.
  always @(negedge clk) begin
    if (sdram_ack_o) ack_pulses++;
    if (vid_rdy_o && cpu_rdy_o) begin
      chk("both_rdy", 1, 0);
    end else if (vid_rdy_o || cpu_rdy_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("word_owner", {31'b0, cpu_rdy_o}, {31'b0, mon_e.cpu});
        chk("word_addr", {8'b0, sdram_addr_x16_o}, {8'b0, mon_e.addr});
        chk("word_wr", {31'b0, sdram_wr_o}, {31'b0, mon_e.wr});
        chk("word_wdata", {16'b0, sdram_wdata_o}, {16'b0, mon_e.wdata});
        chk("word_rdata", {16'b0, cpu_rdy_o ? cpu_rdata_o : vid_rdata_o}, {16'b0, mon_e.rdata});
        chk("req_held", {31'b0, sdram_rd_o | sdram_wr_o}, 1);
        if (cpu_rdy_o) cpu_words++; else vid_words++;
        $display("word %s addr=%06h wr=%0d data=%04h", cpu_rdy_o ? "cpu" : "vid",
                 sdram_addr_x16_o, sdram_wr_o, cpu_rdy_o ? cpu_rdata_o : vid_rdata_o);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    @(negedge clk);
    chk({tag, "_rd"}, {31'b0, sdram_rd_o}, 0);
    chk({tag, "_wr"}, {31'b0, sdram_wr_o}, 0);
    chk({tag, "_ack"}, {31'b0, sdram_ack_o}, 0);
    chk({tag, "_vid_rdy"}, {31'b0, vid_rdy_o}, 0);
    chk({tag, "_cpu_rdy"}, {31'b0, cpu_rdy_o}, 0);
    chk({tag, "_addr"}, {8'b0, sdram_addr_x16_o}, 0);
    chk({tag, "_wdata"}, {16'b0, sdram_wdata_o}, 0);
  endtask

  // Controller side: n ready words to the current owner, then one owner ACK cycle.
  task automatic burst(input bit is_cpu, input int n, input logic [15:0] seed);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.cpu   = is_cpu;
      e.addr  = is_cpu ? cpu_addr_x16_i : vid_addr_x16_i;
      e.wr    = is_cpu ? cpu_wr_i : 1'b0;
      e.wdata = is_cpu ? cpu_wdata_i : 16'h0;
      e.rdata = seed + 16'(i);
      sb.push_back(e);
      sdram_rdy_i   = 1'b1;
      sdram_rdata_i = e.rdata;
      step();
    end
    sdram_rdy_i   = 1'b0;
    sdram_rdata_i = 16'h0;
    if (is_cpu) cpu_ack_i = 1'b1; else vid_ack_i = 1'b1;
    @(negedge clk);
    chk("ack_fwd", {31'b0, sdram_ack_o}, 1);
    step();
    cpu_ack_i = 1'b0;
    vid_ack_i = 1'b0;
  endtask

  task automatic wait_grant(output bit is_cpu);
    is_cpu = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (sdram_rd_o || sdram_wr_o) begin
        is_cpu = (sdram_addr_x16_o == cpu_addr_x16_i);
        step();
        return;
      end
      step();
    end
    chk("grant_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         got_cpu;
    int         a0, c0;
    logic [5:0] fair_seq;

    rst_i = 1'b1;
    vid_rd_i = 0; vid_ack_i = 0; vid_addr_x16_i = 0;
    cpu_rd_i = 0; cpu_wr_i = 0; cpu_ack_i = 0; cpu_addr_x16_i = 0; cpu_wdata_i = 0;
    sdram_rdy_i = 0; sdram_rdata_i = 0;
    step(); step(); step();
    chk_all_zero("reset");
    rst_i = 1'b0;
    step();

    // Video-only 64-word burst
    vid_addr_x16_i = 24'h800000;
    vid_rd_i = 1'b1;
    @(negedge clk);
    chk("vid_grant_pre", {31'b0, sdram_rd_o}, 0);
    step();
    @(negedge clk);
    chk("vid_grant_rd", {31'b0, sdram_rd_o}, 1);
    chk("vid_grant_addr", {8'b0, sdram_addr_x16_o}, 32'h800000);
    step();
    a0 = ack_pulses;
    burst(1'b0, 64, 16'h1000);
    vid_rd_i = 1'b0;
    step(); step();
    chk("vid_words", vid_words, 64);
    chk("cpu_words", cpu_words, 0);
    chk("vid_ack_count", ack_pulses - a0, 1);

    // CPU single-word write, then turnaround timing to the next grant
    cpu_addr_x16_i = 24'h000010;
    cpu_wdata_i = 16'hBEEF;
    cpu_wr_i = 1'b1;
    @(negedge clk);
    chk("cpu_grant_pre", {31'b0, sdram_wr_o}, 0);
    step();
    @(negedge clk);
    chk("cpu_wr", {31'b0, sdram_wr_o}, 1);
    chk("cpu_rd", {31'b0, sdram_rd_o}, 0);
    chk("cpu_addr", {8'b0, sdram_addr_x16_o}, 32'h000010);
    chk("cpu_wdata", {16'b0, sdram_wdata_o}, 32'hBEEF);
    step();
    burst(1'b1, 1, 16'h2000);
    cpu_wr_i = 1'b0;
    cpu_wdata_i = 16'h0;
    vid_addr_x16_i = 24'h400100;
    vid_rd_i = 1'b1;
    @(negedge clk);
    chk("gap_release", {31'b0, sdram_rd_o}, 0);
    step();
    @(negedge clk);
    chk("gap_idle", {31'b0, sdram_rd_o}, 0);
    step();
    @(negedge clk);
    chk("regrant_rd", {31'b0, sdram_rd_o}, 1);
    chk("regrant_addr", {8'b0, sdram_addr_x16_o}, 32'h400100);
    step();

    // Stray CPU ACK during video burst, then reset at word 10
    for (int i = 0; i < 11; i++) begin
      exp_t e;
      e.cpu = 1'b0; e.addr = vid_addr_x16_i; e.wr = 1'b0; e.wdata = 16'h0;
      e.rdata = 16'h3000 + 16'(i);
      sb.push_back(e);
      sdram_rdy_i = 1'b1;
      sdram_rdata_i = e.rdata;
      cpu_ack_i = (i == 2);
      rst_i = (i == 10);
      if (i == 2) begin
        @(negedge clk);
        chk("stray_ack", {31'b0, sdram_ack_o}, 0);
      end
      step();
    end
    cpu_ack_i = 1'b0;
    rst_i = 1'b0;
    sdram_rdata_i = 16'h0;
    chk_all_zero("midrst");
    step();
    sdram_rdy_i = 1'b0;
    @(negedge clk);
    chk("rearb_rd", {31'b0, sdram_rd_o}, 1);
    step();
    burst(1'b0, 2, 16'h3100);
    vid_rd_i = 1'b0;
    step(); step();

    // Simultaneous requests: video first, CPU after ACK + 2
    vid_addr_x16_i = 24'h800040;
    cpu_addr_x16_i = 24'h123456;
    vid_rd_i = 1'b1;
    cpu_rd_i = 1'b1;
    step();
    @(negedge clk);
    chk("sim_grant_addr", {8'b0, sdram_addr_x16_o}, 32'h800040);
    step();
    burst(1'b0, 4, 16'h4000);
    vid_rd_i = 1'b0;
    c0 = cpu_words;
    sdram_rdy_i = 1'b1;
    @(negedge clk);
    chk("sim_gap1_rd", {31'b0, sdram_rd_o}, 0);
    chk("sim_gap1_cpu_rdy", {31'b0, cpu_rdy_o}, 0);
    step();
    @(negedge clk);
    chk("sim_gap2_rd", {31'b0, sdram_rd_o}, 0);
    chk("sim_gap2_cpu_rdy", {31'b0, cpu_rdy_o}, 0);
    step();
    sdram_rdy_i = 1'b0;
    @(negedge clk);
    chk("sim_cpu_rd", {31'b0, sdram_rd_o}, 1);
    chk("sim_cpu_addr", {8'b0, sdram_addr_x16_o}, 32'h123456);
    chk("sim_cpu_no_early_word", cpu_words - c0, 0);
    step();
    burst(1'b1, 2, 16'h5000);
    cpu_rd_i = 1'b0;
    step(); step();

    // Video re-requests continuously while CPU waits; bit b = CPU owns burst b
`ifdef SDRAM_ARB_FAIR_EN
    fair_seq = 6'b010000;
`else
    fair_seq = 6'b000000;
`endif
    vid_addr_x16_i = 24'h800080;
    cpu_addr_x16_i = 24'h000200;
    vid_rd_i = 1'b1;
    cpu_rd_i = 1'b1;
    for (int b = 0; b < 6; b++) begin
      wait_grant(got_cpu);
      chk("fair_owner", {31'b0, got_cpu}, {31'b0, fair_seq[b]});
      burst(got_cpu, 1, 16'h6000 + 16'(b));
      if (got_cpu) cpu_rd_i = 1'b0;
    end
    vid_rd_i = 1'b0;
    cpu_rd_i = 1'b0;
    step(); step(); step();
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
